// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - Pong ball motion engine: serve, wall/paddle bounce, score pulses.
// Define BALL_SPEEDUP_EN to make every paddle hit raise ball speed up to MAX_SPEED.
module ball_controller #(
   parameter int POS_W        = 10,
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_L_X   = 16,
   parameter int PADDLE_R_X   = 616,
   parameter int SPEED        = 2,
   parameter int MAX_SPEED    = 6,
   parameter int SERVE_FRAMES = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             en,
   input  logic [POS_W-1:0] paddle_l_y,
   input  logic [POS_W-1:0] paddle_r_y,
   output logic [POS_W-1:0] ball_x,
   output logic [POS_W-1:0] ball_y,
   output logic             score_l,
   output logic             score_r,
   output logic             serving
);
   localparam int W     = POS_W + 1;
   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
`ifdef BALL_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif
   // Without speed-up the cap equals the base speed, so a hit leaves speed unchanged.
   localparam int SPEED_CAP = SPEEDUP ? MAX_SPEED : SPEED;

   localparam logic [POS_W-1:0] CX      = POS_W'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [POS_W-1:0] CY      = POS_W'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [POS_W-1:0] L_STOP  = POS_W'(PADDLE_L_X + PADDLE_W);
   localparam logic [POS_W-1:0] R_STOP  = POS_W'(PADDLE_R_X - BALL_SIZE);
   localparam logic [POS_W-1:0] Y_STOP  = POS_W'(SCREEN_H - BALL_SIZE);
   localparam logic [POS_W-1:0] SPD_0   = POS_W'(SPEED);
   localparam logic [POS_W-1:0] SPD_CAP = POS_W'(SPEED_CAP);
   localparam logic [W-1:0]     L_FACE  = W'(PADDLE_L_X + PADDLE_W);
   localparam logic [W-1:0]     R_FACE  = W'(PADDLE_R_X);
   localparam logic [W-1:0]     X_MAX   = W'(SCREEN_W - BALL_SIZE);
   localparam logic [W-1:0]     H_W     = W'(SCREEN_H);
   localparam logic [W-1:0]     SIZE    = W'(BALL_SIZE);
   localparam logic [W-1:0]     PAD_H   = W'(PADDLE_H);

   typedef enum logic [1:0] {SERVE, MOVE, SCORED} state_t;

   state_t           state;
   logic [CNT_W-1:0] serve_cnt;
   logic             dir_x;          // 1 = right
   logic             dir_y;          // 1 = down
   logic [POS_W-1:0] speed;

   logic             tick;
   logic [W-1:0]     bx, by, spd, pl, pr;
   logic             overlap_l, overlap_r;
   logic             hit_l, hit_r, miss_l, miss_r;
   logic [POS_W-1:0] x_step, y_next, speed_hit;
   logic             dir_y_next;

   assign tick = frame_tick & en;
   assign bx   = {1'b0, ball_x};
   assign by   = {1'b0, ball_y};
   assign spd  = {1'b0, speed};
   assign pl   = {1'b0, paddle_l_y};
   assign pr   = {1'b0, paddle_r_y};

   assign overlap_l = (by + SIZE > pl) && (by < pl + PAD_H);
   assign overlap_r = (by + SIZE > pr) && (by < pr + PAD_H);

   // A ball already past a paddle face can never bounce off it.
   assign hit_l  = !dir_x && (bx <= L_FACE + spd) && (bx >= L_FACE) && overlap_l;
   assign hit_r  =  dir_x && (bx + spd + SIZE >= R_FACE) && (bx + SIZE <= R_FACE) && overlap_r;
   assign miss_l = !dir_x && (bx < spd);
   assign miss_r =  dir_x && (bx + spd > X_MAX);
   assign x_step = dir_x ? ball_x + speed : ball_x - speed;

   assign speed_hit = (speed >= SPD_CAP) ? SPD_CAP : speed + 1'b1;

   // Touching either wall counts as a bounce, so top and bottom behave symmetrically.
   always_comb begin
      y_next     = ball_y;
      dir_y_next = dir_y;
      if (dir_y) begin
         if (by + spd + SIZE >= H_W) begin
            y_next     = Y_STOP;
            dir_y_next = 1'b0;
         end else begin
            y_next = ball_y + speed;
         end
      end else begin
         if (by <= spd) begin
            y_next     = '0;
            dir_y_next = 1'b1;
         end else begin
            y_next = ball_y - speed;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SERVE;
         serve_cnt <= '0;
         ball_x    <= CX;
         ball_y    <= CY;
         dir_x     <= 1'b1;
         dir_y     <= 1'b1;
         speed     <= SPD_0;
         score_l   <= 1'b0;
         score_r   <= 1'b0;
         serving   <= 1'b1;
      end else begin
         case (state)
            SERVE: begin
               if (tick) begin
                  if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                     state     <= MOVE;
                     serve_cnt <= '0;
                     serving   <= 1'b0;
                  end else begin
                     serve_cnt <= serve_cnt + 1'b1;
                  end
               end
            end
            MOVE: begin
               if (tick) begin
                  ball_y <= y_next;
                  dir_y  <= dir_y_next;
                  if (hit_l) begin
                     ball_x <= L_STOP;
                     dir_x  <= 1'b1;
                     speed  <= speed_hit;
                  end else if (hit_r) begin
                     ball_x <= R_STOP;
                     dir_x  <= 1'b0;
                     speed  <= speed_hit;
                  end else if (miss_l) begin
                     score_r <= 1'b1;
                     state   <= SCORED;
                  end else if (miss_r) begin
                     score_l <= 1'b1;
                     state   <= SCORED;
                  end else begin
                     ball_x <= x_step;
                  end
               end
            end
            SCORED: begin
               // Serve toward the player who just conceded.
               dir_x   <= score_l;
               ball_x  <= CX;
               ball_y  <= CY;
               speed   <= SPD_0;
               score_l <= 1'b0;
               score_r <= 1'b0;
               serving <= 1'b1;
               state   <= SERVE;
            end
            default: state <= SERVE;
         endcase
      end
   end
endmodule
